// File: rtl/fetch_queue_pkg.sv
// rtl/fetch_queue_pkg.sv - shared constants for the instruction fetch queue
package fetch_queue_pkg;

  // Instruction word presented to decode when no instruction is available.
  localparam int NOP = 0;

  // Default sequential program-counter step.
  localparam int DEFAULT_PC_INCREMENT = 2;

endpackage

// File: rtl/fetch_queue_fifo_sync.sv
// rtl/fetch_queue_fifo_sync.sv - synchronous FIFO holding fetched {pc, instr} entries
module fifo_sync #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       clear,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  // A push into a full queue is legal only when the head leaves in the same cycle.
  assign do_push = push & (~full | pop);
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  // Pointer and occupancy tracking; clear wins over any push/pop.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage; contents are only meaningful between push and pop.
  always_ff @(posedge clock) begin
    if (do_push && !clear) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - instruction fetch unit with one in-flight request and a decode queue
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int PC_WIDTH     = 12,
  parameter int PMEM_WIDTH   = 16,
  parameter int PC_INCREMENT = DEFAULT_PC_INCREMENT,
  parameter int DEPTH        = 4,
  parameter int RESET_PC     = 0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_set_pc,
  input  logic [PC_WIDTH-1:0]   in_new_pc,
  input  logic                  in_flush,
  input  logic                  in_ready,
  output logic                  out_pmem_req,
  output logic [PC_WIDTH-1:0]   out_pmem_addr,
  input  logic [PMEM_WIDTH-1:0] in_pmem_instr,
  output logic                  out_valid,
  output logic [PC_WIDTH-1:0]   out_pc,
  output logic [PMEM_WIDTH-1:0] out_instr
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int PW = CW + 1;
  localparam int EW = PC_WIDTH + PMEM_WIDTH;

  logic [PC_WIDTH-1:0] fetch_pc;
  logic [PC_WIDTH-1:0] inflight_pc;
  logic                inflight;
  logic                redirect;
  logic                issue;
  logic                push;
  logic                pop;
  logic [PW-1:0]       pending;
  logic [CW-1:0]       count;
  logic                full;
  logic                empty;
  logic [EW-1:0]       head;

  assign redirect = in_set_pc | in_flush;
  // Slots already promised: queued entries plus the response still on its way.
  // A pop in this cycle does not free a slot until the next cycle.
  assign pending  = {1'b0, count} + PW'(inflight);
  assign issue    = reset & ~redirect & ~full & (pending < PW'(DEPTH));
  // Responses arriving during a redirect belong to the old stream and are dropped.
  assign push     = inflight & ~redirect;
  assign pop      = ~empty & in_ready & ~redirect;

  assign out_pmem_req  = issue;
  assign out_pmem_addr = fetch_pc;
  assign out_valid     = ~empty;
  assign out_pc        = empty ? '0 : head[EW-1:PMEM_WIDTH];
  assign out_instr     = empty ? PMEM_WIDTH'(NOP) : head[PMEM_WIDTH-1:0];

  // Fetch PC: redirect loads the target, flush holds, each issued request steps it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fetch_pc <= PC_WIDTH'(RESET_PC);
    end else if (in_set_pc) begin
      fetch_pc <= in_new_pc;
    end else if (issue) begin
      fetch_pc <= fetch_pc + PC_WIDTH'(PC_INCREMENT);
    end
  end

  // In-flight tracker: remembers the PC of the request whose data arrives next cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else begin
      inflight <= issue;
      if (issue) inflight_pc <= fetch_pc;
    end
  end

  fifo_sync #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_queue (
    .clock (clock),
    .reset (reset),
    .clear (redirect),
    .push  (push),
    .pop   (pop),
    .din   ({inflight_pc, in_pmem_instr}),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - self-checking bench for fetch_queue against a queue-based reference model
module tb_fetch_queue;

  localparam int PCW   = 12;
  localparam int IW    = 16;
  localparam int INC   = 2;
  localparam int DEPTH = 4;
  localparam int RPC   = 0;

  logic           clock = 1'b0;
  logic           reset;
  logic           in_set_pc;
  logic [PCW-1:0] in_new_pc;
  logic           in_flush;
  logic           in_ready;
  logic           out_pmem_req;
  logic [PCW-1:0] out_pmem_addr;
  logic [IW-1:0]  in_pmem_instr;
  logic           out_valid;
  logic [PCW-1:0] out_pc;
  logic [IW-1:0]  out_instr;

  logic [PCW-1:0] last_addr = '0;

  int n_cmp = 0;
  int n_bad = 0;
  int req_seen;

  // Reference model state: fetch PC, in-flight PC, and the queue as a list of PCs.
  int m_pc;
  bit m_inflight;
  int m_inflight_pc;
  int m_q[$];

  always #5 clock = ~clock;

  fetch_queue #(
    .PC_WIDTH     (PCW),
    .PMEM_WIDTH   (IW),
    .PC_INCREMENT (INC),
    .DEPTH        (DEPTH),
    .RESET_PC     (RPC)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .in_set_pc     (in_set_pc),
    .in_new_pc     (in_new_pc),
    .in_flush      (in_flush),
    .in_ready      (in_ready),
    .out_pmem_req  (out_pmem_req),
    .out_pmem_addr (out_pmem_addr),
    .in_pmem_instr (in_pmem_instr),
    .out_valid     (out_valid),
    .out_pc        (out_pc),
    .out_instr     (out_instr)
  );

  function automatic logic [IW-1:0] pmem_fn(input int addr);
    logic [PCW-1:0] a;
    a = addr[PCW-1:0];
    return {4'hA, a} ^ 16'h0F0F;
  endfunction

  // Program memory: returns the word for the address presented one cycle earlier.
  always @(posedge clock) last_addr <= out_pmem_addr;
  assign in_pmem_instr = pmem_fn(int'(last_addr));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = RPC;
    m_inflight = 0;
    m_inflight_pc = 0;
    m_q.delete();
  endtask

  // One clock cycle: apply inputs, compare outputs with the model, advance the model.
  task automatic step(input logic rdy, input logic setp, input logic [PCW-1:0] npc, input logic fl);
    bit e_req;
    bit e_valid;
    int e_pc;
    int e_instr;
    in_ready  = rdy;
    in_set_pc = setp;
    in_new_pc = npc;
    in_flush  = fl;
    #1;
    e_req   = !setp && !fl && (m_q.size() + int'(m_inflight) < DEPTH);
    e_valid = m_q.size() > 0;
    e_pc    = e_valid ? m_q[0] : 0;
    e_instr = e_valid ? int'(pmem_fn(m_q[0])) : 0;
    check("pmem_req",  32'(out_pmem_req), 32'(e_req));
    check("pmem_addr", 32'(out_pmem_addr), 32'(m_pc));
    check("out_valid", 32'(out_valid), 32'(e_valid));
    check("out_pc",    32'(out_pc), 32'(e_pc));
    check("out_instr", 32'(out_instr), 32'(e_instr));
    req_seen += int'(out_pmem_req);
    @(posedge clock);
    if (setp) begin
      m_q.delete();
      m_inflight = 0;
      m_pc = int'(npc);
    end else if (fl) begin
      m_q.delete();
      m_inflight = 0;
    end else begin
      if (e_valid && rdy) void'(m_q.pop_front());
      if (m_inflight) m_q.push_back(m_inflight_pc);
      m_inflight = e_req;
      if (e_req) begin
        m_inflight_pc = m_pc;
        m_pc = (m_pc + INC) % (1 << PCW);
      end
    end
    @(negedge clock);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"},   32'(out_pmem_req), 32'd0);
    check({tag, "_addr"},  32'(out_pmem_addr), 32'(RPC));
    check({tag, "_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_pc"},    32'(out_pc), 32'd0);
    check({tag, "_instr"}, 32'(out_instr), 32'd0);
  endtask

  initial begin
    reset = 1'b0;
    in_set_pc = 1'b0;
    in_new_pc = '0;
    in_flush = 1'b0;
    in_ready = 1'b0;
    model_reset();
    @(negedge clock);
    #1;
    check_reset_outputs("rst");
    @(negedge clock);
    reset = 1'b1;

    // Streaming with decode always ready: requests 0,2,4,... and two-cycle latency.
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, '0, 1'b0);

    // Redirect somewhere, then stall decode: exactly DEPTH requests before stopping.
    step(1'b0, 1'b1, 12'h000, 1'b0);
    req_seen = 0;
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, '0, 1'b0);
    check("stall_req_count", 32'(req_seen), 32'(DEPTH));
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, '0, 1'b0);

    // Fill the queue, free one slot so a request is in flight, then redirect to 0x100.
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, '0, 1'b0);
    step(1'b1, 1'b0, '0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0);
    step(1'b0, 1'b1, 12'h100, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, '0, 1'b0);

    // Stall until the fetch PC sits at 0x020, then flush for one cycle.
    step(1'b0, 1'b1, 12'h018, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, '0, 1'b0);
    step(1'b1, 1'b0, '0, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, '0, 1'b0);

    // Redirect with the flush also high, to the top of the address space: wraps to 0.
    step(1'b1, 1'b1, 12'hFFE, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, '0, 1'b0);

    // Asynchronous reset mid-stream: outputs drop immediately.
    reset = 1'b0;
    model_reset();
    #1;
    check_reset_outputs("midrst");
    @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, '0, 1'b0);

    // Randomized traffic: stalls, redirects and flushes mixed in.
    for (int i = 0; i < 400; i++) begin
      logic           r;
      logic           s;
      logic           f;
      logic [PCW-1:0] np;
      r  = ($urandom_range(0, 3) != 0);
      s  = ($urandom_range(0, 29) == 0);
      f  = ($urandom_range(0, 29) == 0);
      np = PCW'($urandom) & 12'hFFE;
      step(r, s, np, f);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
